// File: rtl/transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : transmitter_if
// Description : Parallel byte handshake between a byte source and the UART
//               transmitter. The source drives tx_data/tx_valid and the
//               transmitter answers with tx_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface transmitter_if #(
  parameter int DATA_SIZE = 8
) ();

  logic [DATA_SIZE-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Byte source side
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/transmitter.sv
`default_nettype none
// ============================================================================
// Module      : transmitter
// Description : UART transmitter on the oversampled bit clock. Accepts bytes
//               through a valid/ready handshake into a single holding
//               register and sends start, DATA_SIZE data bits (LSB first)
//               and stop. A byte waiting in the holding register is loaded
//               on the edge that ends the stop bit, so frames run back to
//               back with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module transmitter #(
  parameter int DATA_SIZE  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic          bclk_x8,
  input  logic          rst_n,
  transmitter_if.slave  tx_bus,
  output logic          tx_out,
  output logic          tx_status,
  output logic          tx_done
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  logic [1:0]           r_state;
  logic [TICK_W-1:0]    r_tick;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_SIZE-1:0] r_shift;
  logic [DATA_SIZE-1:0] r_hold_data;
  logic                 r_hold_full;
  logic                 r_tx_out;

  logic [1:0]           w_state_nxt;
  logic [TICK_W-1:0]    w_tick_nxt;
  logic [BIT_W-1:0]     w_bit_nxt;
  logic [DATA_SIZE-1:0] w_shift_nxt;
  logic                 w_tx_out_nxt;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_bit_end;

  // Holding register can only be written while empty, so a load and an
  // accept never collide.
  assign w_accept        = tx_bus.tx_valid & ~r_hold_full;
  assign tx_bus.tx_ready = ~r_hold_full;
  assign w_bit_end       = (r_tick == TICK_LAST);

  assign tx_out    = r_tx_out;
  assign tx_status = (r_state != IDLE);
  assign tx_done   = (r_state == STOP) && w_bit_end;

  // Next-state, counters and shift register; tx_out is derived from the
  // next state so the line changes on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = (r_state == IDLE) ? '0 : r_tick + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_state_nxt = START;
          w_shift_nxt = r_hold_data;
          w_load      = 1'b1;
          w_tick_nxt  = '0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_tick_nxt  = '0;
          w_bit_nxt   = r_bit + 1'b1;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_tick_nxt = '0;
          if (r_hold_full) begin
            w_state_nxt = START;
            w_shift_nxt = r_hold_data;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tick_nxt  = '0;
      end
    endcase

    case (w_state_nxt)
      START:   w_tx_out_nxt = 1'b0;
      DATA:    w_tx_out_nxt = w_shift_nxt[0];
      default: w_tx_out_nxt = 1'b1;
    endcase
  end

  // Frame state, counters, shift register and the registered line driver.
  always_ff @(posedge bclk_x8 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx_out <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_tx_out <= w_tx_out_nxt;
    end
  end

  // Holding register: filled on accept, emptied when moved to the shifter.
  always_ff @(posedge bclk_x8 or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_data <= tx_bus.tx_data;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_transmitter
// Description : Self-checking bench for the UART transmitter. Accepted bytes
//               go into a scoreboard queue; a line monitor decodes every
//               frame cycle by cycle and compares it against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transmitter;

  localparam int DS    = 8;
  localparam int OS    = 8;
  localparam int FRAME = (DS + 2) * OS;

  logic bclk_x8 = 1'b0;
  logic rst_n   = 1'b0;
  logic tx_out;
  logic tx_status;
  logic tx_done;

  transmitter_if #(.DATA_SIZE(DS)) bus ();

  transmitter #(.DATA_SIZE(DS), .OVERSAMPLE(OS)) dut (
    .bclk_x8   (bclk_x8),
    .rst_n     (rst_n),
    .tx_bus    (bus),
    .tx_out    (tx_out),
    .tx_status (tx_status),
    .tx_done   (tx_done)
  );

  always #5 bclk_x8 = ~bclk_x8;

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and monitor bookkeeping
  logic [DS-1:0] exp_q[$];
  int            start_times[$];
  int            done_times[$];
  int            cyc = 0;
  int            frames_rcvd = 0;
  int            idle_bad = 0;

  bit            mon_active = 1'b0;
  int            mon_cnt = 0;
  int            mon_bad = 0;
  logic [DS-1:0] mon_exp;
  logic [DS-1:0] rx_byte;

  always @(posedge bclk_x8) cyc <= cyc + 1;

  // Line monitor: sampled on the falling edge, away from the active edge.
  always @(negedge bclk_x8) begin
    logic exp_bit;
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx_out == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_bad    = 0;
        rx_byte    = '0;
        start_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          mon_exp = '0;
        end else begin
          mon_exp = exp_q.pop_front();
        end
      end
      if (mon_active) begin
        if (mon_cnt < OS)                exp_bit = 1'b0;
        else if (mon_cnt < (DS + 1) * OS) exp_bit = mon_exp[(mon_cnt - OS) / OS];
        else                             exp_bit = 1'b1;
        if (tx_out !== exp_bit) mon_bad++;
        if (tx_status !== 1'b1) mon_bad++;
        if (tx_done !== (mon_cnt == FRAME - 1)) mon_bad++;
        if (tx_done === 1'b1) done_times.push_back(cyc);
        if (mon_cnt >= OS && mon_cnt < (DS + 1) * OS && (mon_cnt % OS) == OS / 2)
          rx_byte[(mon_cnt - OS) / OS] = tx_out;
        if (mon_cnt == FRAME - 1) begin
          check("frame_shape", mon_bad, 0);
          check("rx_byte", rx_byte, mon_exp);
          check("stop_done", tx_done, 1'b1);
          frames_rcvd++;
          mon_active = 1'b0;
        end else begin
          mon_cnt++;
        end
      end else if (tx_done !== 1'b0 || tx_status !== 1'b0) begin
        idle_bad++;
      end
    end
  end

  // Entered and left at posedge+1: offer one byte once ready is high.
  task automatic send(input logic [DS-1:0] b);
    int guard = 0;
    while (!bus.tx_ready && guard < 1000) begin
      @(posedge bclk_x8); #1;
      guard++;
    end
    if (!bus.tx_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      @(posedge bclk_x8);
      exp_q.push_back(b);
      #1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = DS'($urandom);
      check("ready_low_after_accept", bus.tx_ready, 1'b0);
    end
  endtask

  // Bounded wait for the scoreboard to drain and the line to go idle.
  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || mon_active || tx_status) && guard < 2000) begin
      @(posedge bclk_x8); #1;
      guard++;
    end
    if (guard >= 2000) check("idle_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge bclk_x8);
    #1;
  endtask

  initial begin
    int frames0;
    int idle0;
    int guard;

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(posedge bclk_x8);
    #1;
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_tx_ready", bus.tx_ready, 1'b1);
    check("rst_tx_status", tx_status, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    @(negedge bclk_x8);
    rst_n = 1'b1;

    // Idle line
    repeat (200) @(posedge bclk_x8);
    #1;
    check("idle_line_bad", idle_bad, 0);
    check("idle_frames", frames_rcvd, 0);
    check("idle_tx_out", tx_out, 1'b1);

    // Single byte
    start_times.delete();
    done_times.delete();
    send(8'hA5);
    @(posedge bclk_x8); #1;
    check("start_low", tx_out, 1'b0);
    check("ready_back", bus.tx_ready, 1'b1);
    check("status_high", tx_status, 1'b1);
    wait_idle();
    check("single_frames", frames_rcvd, 1);
    check("single_done_cnt", done_times.size(), 1);
    check("done_latency", done_times[0] - start_times[0], FRAME - 1);
    check("single_status_low", tx_status, 1'b0);

    // Back-to-back
    start_times.delete();
    done_times.delete();
    frames0 = frames_rcvd;
    send(8'h00);
    repeat (20) @(posedge bclk_x8);
    #1;
    send(8'hFF);
    wait_idle();
    check("b2b_frames", frames_rcvd - frames0, 2);
    check("b2b_start_cnt", start_times.size(), 2);
    check("b2b_gap", start_times[1] - start_times[0], FRAME);
    check("b2b_done_gap", done_times[1] - done_times[0], FRAME);

    // Backpressure: valid held with changing data while the holder is full
    frames0 = frames_rcvd;
    send(8'h12);
    send(8'h34);
    guard = 0;
    while (!bus.tx_ready && guard < 300) begin
      bus.tx_data  = DS'($urandom);
      bus.tx_valid = 1'b1;
      @(posedge bclk_x8); #1;
      guard++;
    end
    bus.tx_valid = 1'b0;
    check("bp_ready_seen", bus.tx_ready, 1'b1);
    wait_idle();
    check("bp_frames", frames_rcvd - frames0, 2);

    // Reset in the middle of data bit 4 with a byte buffered
    frames0 = frames_rcvd;
    send(8'hC3);
    send(8'h77);
    guard = 0;
    while (!(mon_active && mon_cnt == OS + 4 * OS + 3) && guard < 500) begin
      @(posedge bclk_x8); #1;
      guard++;
    end
    check("reset_point_reached", guard < 500, 1'b1);
    check("pre_reset_ready", bus.tx_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_tx_out", tx_out, 1'b1);
    check("async_rst_ready", bus.tx_ready, 1'b1);
    check("async_rst_status", tx_status, 1'b0);
    repeat (3) @(posedge bclk_x8);
    @(negedge bclk_x8);
    rst_n = 1'b1;
    idle0 = idle_bad;
    repeat (100) @(posedge bclk_x8);
    #1;
    check("post_rst_no_frame", frames_rcvd - frames0, 0);
    check("post_rst_idle", idle_bad - idle0, 0);
    send(8'h3C);
    wait_idle();
    check("post_rst_frames", frames_rcvd - frames0, 1);

    // Loopback patterns
    frames0 = frames_rcvd;
    send(8'h55);
    send(8'hAA);
    send(8'h01);
    send(8'h80);
    wait_idle();
    check("loop_frames", frames_rcvd - frames0, 4);

    check("final_idle_bad", idle_bad, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
